sync_fifo_prog: RTL and testbench

Parametrised synchronous FIFO that succeeds the basic decoder FIFO. It adds a first-word-fall-through (FWFT) mode, programmable almost-full and almost-empty flags, an occupancy output, a synchronous flush, sticky overflow and underflow flags, and write-through when full. It buffers symbol and branch-metric words and decoded-bit words between the Viterbi stages (branch metric unit, ACS, traceback, output) in a single clock domain.

---
 rtl/sync_fifo_prog_pkg.sv | 11 +
 rtl/sync_fifo_prog_if.sv | 35 +++
 rtl/sync_fifo_prog_regfile.sv | 24 ++
 rtl/sync_fifo_prog.sv | 107 ++++++++++
 tb/tb_sync_fifo_prog.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_prog_pkg.sv
// Shared definitions for the programmable FIFO: read-mode encodings and the
// occupancy-counter width helper.
package fifo_pkg;
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Occupancy spans 0..DEPTH inclusive, so one bit wider than the pointers.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_prog_if.sv
// Write/read handshake bundle for sync_fifo_prog; master drives requests, slave is the FIFO.
interface sync_fifo_prog_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
);
  localparam int LW = lvl_width(DEPTH);

  logic                  flush_i;
  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  full_o;
  logic                  almost_full_o;
  logic                  rd_en_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  rd_valid_o;
  logic                  empty_o;
  logic                  almost_empty_o;
  logic [LW-1:0]         level_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output flush_i, wr_en_i, wr_data_i, rd_en_i,
    input  full_o, almost_full_o, rd_data_o, rd_valid_o, empty_o,
           almost_empty_o, level_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, wr_en_i, wr_data_i, rd_en_i,
    output full_o, almost_full_o, rd_data_o, rd_valid_o, empty_o,
           almost_empty_o, level_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/sync_fifo_prog_regfile.sv
// DATA_WIDTH x DEPTH flop array: one synchronous write port, one combinational read port.
module fifo_regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  // Reset clears the array so a fall-through read port shows zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with FWFT/registered read modes, programmable almost flags,
// occupancy output, synchronous flush, and sticky overflow/underflow.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 16,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  sync_fifo_prog_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_width(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      AEMPTY_THRESH < 0 || AEMPTY_THRESH >= AFULL_THRESH || AFULL_THRESH > DEPTH ||
      (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT)) begin : g_bad_cfg
    $error("sync_fifo_prog: illegal DEPTH/threshold/mode configuration");
  end

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level;
  logic                  full, empty, rd_acc, wr_acc;
  logic                  ovf_q, unf_q;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Status decodes look only at the registered level, never at this cycle's requests.
  assign full   = (level == LW'(DEPTH));
  assign empty  = (level == '0);
  assign rd_acc = bus.rd_en_i && !empty;
  assign wr_acc = bus.wr_en_i && (!full || rd_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (bus.wr_en_i && !wr_acc) ovf_q <= 1'b1;
      if (bus.rd_en_i && empty)   unf_q <= 1'b1;
    end
  end

  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc && !bus.flush_i),
    .waddr (wr_ptr),
    .wdata (bus.wr_data_i),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  if (FWFT == FIFO_MODE_STD) begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_vld_q;

    // Data register holds across flush; only the valid strobe is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q <= '0;
        rd_vld_q  <= 1'b0;
      end else if (bus.flush_i) begin
        rd_vld_q  <= 1'b0;
      end else begin
        rd_vld_q  <= rd_acc;
        if (rd_acc) rd_data_q <= mem_rdata;
      end
    end

    assign bus.rd_data_o  = rd_data_q;
    assign bus.rd_valid_o = rd_vld_q;
  end else begin : g_fwft
    assign bus.rd_data_o  = mem_rdata;
    assign bus.rd_valid_o = !empty;
  end

  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.almost_full_o  = (level >= LW'(AFULL_THRESH));
  assign bus.almost_empty_o = (level <= LW'(AEMPTY_THRESH));
  assign bus.level_o        = level;
  assign bus.overflow_o     = ovf_q;
  assign bus.underflow_o    = unf_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Drives a standard-read and an FWFT instance (DEPTH=4) with identical stimulus and
// checks both against a queue-based model every cycle, plus hand-computed spot checks.
module tb_sync_fifo_prog;
  localparam int DW = 16;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic          clk, rst_n;
  logic          flush, wr_en, rd_en;
  logic [DW-1:0] wr_data;

  sync_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH(D)) sif ();
  sync_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH(D)) fif ();

  assign sif.flush_i = flush;  assign fif.flush_i = flush;
  assign sif.wr_en_i = wr_en;  assign fif.wr_en_i = wr_en;
  assign sif.wr_data_i = wr_data; assign fif.wr_data_i = wr_data;
  assign sif.rd_en_i = rd_en;  assign fif.rd_en_i = rd_en;

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(0), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE))
    u_std (.clk(clk), .rst_n(rst_n), .bus(sif));
  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(1), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE))
    u_fwft (.clk(clk), .rst_n(rst_n), .bus(fif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, sticky flags, registered-read output.
  logic [DW-1:0] q[$];
  bit            m_ovf = 0, m_unf = 0, m_vld = 0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_vld = 0; m_data = '0;
    end else if (flush) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_vld = 0;
    end else begin
      bit was_empty, was_full, racc, wacc;
      was_empty = (q.size() == 0);
      was_full  = (q.size() == D);
      racc = rd_en && !was_empty;
      wacc = wr_en && (!was_full || racc);
      if (wr_en && !wacc) m_ovf = 1;
      if (rd_en && was_empty) m_unf = 1;
      m_vld = racc;
      if (racc) m_data = q.pop_front();
      if (wacc) q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (started && rst_n) begin
      int lv;
      lv = q.size();
      chk("std.level", sif.level_o, lv);
      chk("std.full", sif.full_o, lv == D);
      chk("std.empty", sif.empty_o, lv == 0);
      chk("std.afull", sif.almost_full_o, lv >= AF);
      chk("std.aempty", sif.almost_empty_o, lv <= AE);
      chk("std.ovf", sif.overflow_o, m_ovf);
      chk("std.unf", sif.underflow_o, m_unf);
      chk("std.valid", sif.rd_valid_o, m_vld);
      chk("std.data", sif.rd_data_o, m_data);
      chk("fwft.level", fif.level_o, lv);
      chk("fwft.ovf", fif.overflow_o, m_ovf);
      chk("fwft.unf", fif.underflow_o, m_unf);
      chk("fwft.valid", fif.rd_valid_o, lv != 0);
      if (lv != 0) chk("fwft.data", fif.rd_data_o, q[0]);
    end
  end

  task automatic cyc(input bit fl, input bit we, input logic [DW-1:0] wd, input bit re);
    flush = fl; wr_en = we; wr_data = wd; rd_en = re;
    @(posedge clk); #1;
    flush = 0; wr_en = 0; rd_en = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".rst.level"}, sif.level_o, 0);
    chk({tag, ".rst.data"}, sif.rd_data_o, 0);
    chk({tag, ".rst.valid"}, sif.rd_valid_o, 0);
    chk({tag, ".rst.full"}, sif.full_o, 0);
    chk({tag, ".rst.afull"}, sif.almost_full_o, 0);
    chk({tag, ".rst.ovf"}, sif.overflow_o, 0);
    chk({tag, ".rst.unf"}, sif.underflow_o, 0);
    chk({tag, ".rst.empty"}, sif.empty_o, 1);
    chk({tag, ".rst.aempty"}, sif.almost_empty_o, 1);
    chk({tag, ".rst.f.level"}, fif.level_o, 0);
    chk({tag, ".rst.f.data"}, fif.rd_data_o, 0);
    chk({tag, ".rst.f.valid"}, fif.rd_valid_o, 0);
    chk({tag, ".rst.f.empty"}, fif.empty_o, 1);
  endtask

  initial begin
    rst_n = 0; flush = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    #1;
    started = 1'b1;
    chk_reset_vals("init");
    #20;
    @(negedge clk); #2 rst_n = 1;
    @(posedge clk); #1;

    // Fill to full, then drain in order with registered read latency.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, DW'(16'hA1 + i), 0);
      if (i == 1) chk("afull.after2", sif.almost_full_o, 0);
      if (i == 2) chk("afull.after3", sif.almost_full_o, 1);
    end
    chk("fill.full", sif.full_o, 1);
    chk("fill.level", sif.level_o, 4);
    for (int i = 0; i < 4; i++) begin
      chk("fwft.head", fif.rd_data_o, DW'(16'hA1 + i));
      cyc(0, 0, '0, 1);
      chk("rd.data", sif.rd_data_o, DW'(16'hA1 + i));
      chk("rd.valid", sif.rd_valid_o, 1);
    end
    cyc(0, 0, '0, 0);
    chk("drain.valid0", sif.rd_valid_o, 0);
    chk("drain.empty", sif.empty_o, 1);

    // Write-through at full, then a dropped write.
    for (int i = 0; i < 4; i++) cyc(0, 1, DW'(16'hC1 + i), 0);
    cyc(0, 1, 16'h0077, 1);
    chk("wt.data", sif.rd_data_o, 16'h00C1);
    chk("wt.level", sif.level_o, 4);
    chk("wt.ovf", sif.overflow_o, 0);
    cyc(0, 1, 16'h0088, 0);
    chk("ovf.set", sif.overflow_o, 1);
    chk("ovf.level", sif.level_o, 4);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1);
    chk("wt.last", sif.rd_data_o, 16'h0077);

    // Underflow, flush with a concurrent write, then write+read into empty.
    cyc(0, 0, '0, 1);
    chk("unf.set", sif.underflow_o, 1);
    chk("unf.level", sif.level_o, 0);
    cyc(1, 1, 16'h0099, 0);
    chk("flush.level", sif.level_o, 0);
    chk("flush.empty", fif.empty_o, 1);
    chk("flush.ovf", sif.overflow_o, 0);
    chk("flush.unf", fif.underflow_o, 0);
    cyc(0, 1, 16'h005A, 1);
    chk("ew.level", sif.level_o, 1);
    chk("ew.unf", sif.underflow_o, 1);
    chk("ew.f.data", fif.rd_data_o, 16'h005A);
    chk("ew.f.valid", fif.rd_valid_o, 1);
    cyc(0, 0, '0, 1);
    chk("pop.f.empty", fif.empty_o, 1);
    chk("pop.f.valid", fif.rd_valid_o, 0);
    chk("pop.s.data", sif.rd_data_o, 16'h005A);

    // Interleaved traffic across pointer wrap, then randomized traffic.
    for (int i = 0; i < 10; i++) cyc(0, 1, DW'(16'hD0 + i), (i % 3) != 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, '0, 1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 99) < 55, DW'($urandom),
          $urandom_range(0, 99) < 50);

    // Asynchronous reset mid-stream at level 3.
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, DW'(16'hE1 + i), 0);
    chk("pre.level3", sif.level_o, 3);
    cyc(0, 0, '0, 1);
    cyc(0, 1, 16'h00E4, 0);
    #2 rst_n = 0;
    #1;
    chk_reset_vals("mid");
    @(negedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    cyc(0, 1, 16'h1234, 0);
    chk("post.f.data", fif.rd_data_o, 16'h1234);
    cyc(0, 0, '0, 1);
    chk("post.s.data", sif.rd_data_o, 16'h1234);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
